// File: rtl/adc_rd_sched_pkg.sv
// rtl/adc_rd_sched_pkg.sv - shared state encoding and buffer depth for the ADC read scheduler
package adc_rd_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_FLUSH = 3'd4
  } sched_state_e;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/adc_rd_sched_if.sv
// rtl/adc_rd_sched_if.sv - FIFO read port and sample stream between the scheduler and its neighbours
interface adc_rd_sched_if #(
  parameter int ADC_PACK_DATA_WIDTH = 64
) ();

  logic                           emptyn_to_acc;
  logic [ADC_PACK_DATA_WIDTH-1:0] data_to_acc;
  logic                           acc_ask_data;
  logic [ADC_PACK_DATA_WIDTH-1:0] sample_out;
  logic                           sample_valid;
  logic                           sample_ready;

  modport slave (
    input  emptyn_to_acc, data_to_acc, sample_ready,
    output acc_ask_data, sample_out, sample_valid
  );

  modport master (
    output emptyn_to_acc, data_to_acc, sample_ready,
    input  acc_ask_data, sample_out, sample_valid
  );

endinterface

// File: rtl/rx_sample_skid.sv
// rtl/rx_sample_skid.sv - two-entry in-order sample buffer with push, pop, clear and occupancy
module rx_sample_skid
  import adc_rd_sched_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // a push into a full buffer is only taken when the head leaves in the same cycle
  assign do_push = push && ((count < FULL) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head      = mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/adc_rd_sched.sv
// rtl/adc_rd_sched.sv - paced read scheduler between the ADC sample FIFO and the rx datapath
module adc_rd_sched
  import adc_rd_sched_pkg::*;
#(
  parameter int ADC_PACK_DATA_WIDTH = 64,
  parameter int RATE_DIV_WIDTH      = 8,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                      acc_clk,
  input  logic                      acc_rst,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [RATE_DIV_WIDTH-1:0] rate_div,
  input  logic                      clear_cnt,
  adc_rd_sched_if.slave             bus,
  output logic [CNT_WIDTH-1:0]      underrun_cnt,
  output logic [CNT_WIDTH-1:0]      sample_cnt,
  output logic [2:0]                sched_state
);

  sched_state_e                   state;
  logic [RATE_DIV_WIDTH-1:0]      reload;
  logic [RATE_DIV_WIDTH-1:0]      pace_elapsed;
  logic                           tick_pending;
  logic                           rd_pending;
  logic                           quiet_seen;
  logic [1:0]                     occupancy;
  logic [2:0]                     room;
  logic [ADC_PACK_DATA_WIDTH-1:0] head;
  logic                           sample_valid;
  logic                           pop;
  logic                           push;
  logic                           expire;
  logic                           grant;
  logic                           ask;
  logic                           fifo_quiet;

  assign reload = (rate_div == '0) ? '0 : rate_div - RATE_DIV_WIDTH'(1);

  // The pacing down-counter is kept as cycles elapsed since reload (remaining = reload - elapsed),
  // so a zero reset already means "loaded with reload" whatever rate_div is.
  assign expire = (state == S_RUN) && (pace_elapsed >= reload);

  assign sample_valid = (occupancy != 2'd0);
  assign pop          = sample_valid && bus.sample_ready;
  assign room         = {1'b0, occupancy} + {2'b00, rd_pending} - {2'b00, pop};
  assign grant        = (state == S_RUN) && tick_pending && bus.emptyn_to_acc && (room < 3'd2);
  assign ask          = (state == S_FLUSH) ? bus.emptyn_to_acc : grant;
  assign push         = rd_pending && (state != S_FLUSH);
  assign fifo_quiet   = !bus.emptyn_to_acc && !rd_pending;

  rx_sample_skid #(
    .WIDTH(ADC_PACK_DATA_WIDTH)
  ) u_skid (
    .clk      (acc_clk),
    .rst      (acc_rst),
    .push     (push),
    .push_data(bus.data_to_acc),
    .pop      (pop),
    .clear    (flush),
    .head     (head),
    .occupancy(occupancy)
  );

  always_ff @(posedge acc_clk or posedge acc_rst) begin
    if (acc_rst) begin
      state        <= S_IDLE;
      pace_elapsed <= '0;
      tick_pending <= 1'b0;
      rd_pending   <= 1'b0;
      quiet_seen   <= 1'b0;
      underrun_cnt <= '0;
      sample_cnt   <= '0;
    end else begin
      rd_pending <= ask;

      if (state == S_RUN) begin
        pace_elapsed <= expire ? '0 : pace_elapsed + RATE_DIV_WIDTH'(1);
        if (expire && bus.emptyn_to_acc) begin
          tick_pending <= 1'b1;
        end else if (grant) begin
          tick_pending <= 1'b0;
        end
      end else begin
        pace_elapsed <= '0;
        tick_pending <= 1'b0;
      end

      if (clear_cnt) begin
        underrun_cnt <= '0;
        sample_cnt   <= '0;
      end else begin
        if (expire && !bus.emptyn_to_acc && (underrun_cnt != '1)) begin
          underrun_cnt <= underrun_cnt + CNT_WIDTH'(1);
        end
        if (pop && (sample_cnt != '1)) begin
          sample_cnt <= sample_cnt + CNT_WIDTH'(1);
        end
      end

      if (flush) begin
        state      <= S_FLUSH;
        quiet_seen <= 1'b0;
      end else begin
        case (state)
          S_IDLE:  if (enable) state <= S_WAIT;
          S_WAIT: begin
            if (!enable) state <= S_IDLE;
            else if (bus.emptyn_to_acc) state <= S_RUN;
          end
          S_RUN:   if (!enable) state <= S_DRAIN;
          S_DRAIN: begin
            if ((occupancy == 2'd0) && !rd_pending) state <= enable ? S_WAIT : S_IDLE;
          end
          S_FLUSH: begin
            // leave only after two consecutive cycles with nothing left to drain
            if (fifo_quiet) begin
              if (quiet_seen) state <= S_IDLE;
              quiet_seen <= 1'b1;
            end else begin
              quiet_seen <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.acc_ask_data = ask;
  assign bus.sample_out   = head;
  assign bus.sample_valid = sample_valid;
  assign sched_state      = state;

endmodule

// File: tb/tb_adc_rd_sched.sv
// tb/tb_adc_rd_sched.sv - scoreboard bench for adc_rd_sched with a behavioural ADC FIFO
module tb_adc_rd_sched;

  localparam int DW = 64;
  localparam int RW = 8;
  localparam int CW = 8;

  logic          acc_clk = 1'b0;
  logic          acc_rst = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          clear_cnt = 1'b0;
  logic [RW-1:0] rate_div = 8'd1;
  logic [CW-1:0] underrun_cnt;
  logic [CW-1:0] sample_cnt;
  logic [2:0]    sched_state;

  adc_rd_sched_if #(.ADC_PACK_DATA_WIDTH(DW)) bus ();

  adc_rd_sched #(
    .ADC_PACK_DATA_WIDTH(DW),
    .RATE_DIV_WIDTH     (RW),
    .CNT_WIDTH          (CW)
  ) dut (
    .acc_clk     (acc_clk),
    .acc_rst     (acc_rst),
    .enable      (enable),
    .flush       (flush),
    .rate_div    (rate_div),
    .clear_cnt   (clear_cnt),
    .bus         (bus),
    .underrun_cnt(underrun_cnt),
    .sample_cnt  (sample_cnt),
    .sched_state (sched_state)
  );

  always #5 acc_clk = ~acc_clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            hide = 1'b0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            ask_cyc[$];

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock cycle; the FIFO model answers a read one cycle later and refreshes emptyn.
  task automatic step();
    logic asked;
    @(negedge acc_clk);
    asked = bus.acc_ask_data;
    @(posedge acc_clk);
    #1;
    cyc++;
    if (asked) begin
      ask_cyc.push_back(cyc);
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL ask_on_empty got=1 exp=0 cycle=%0d", cyc);
      end else begin
        bus.data_to_acc = fifo_q.pop_front();
      end
    end
    bus.emptyn_to_acc = (fifo_q.size() != 0) && !hide;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fifo_put(logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic fifo_discard();
    fifo_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clear();
    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
  endtask

  task automatic wait_state(string name, logic [2:0] s, int budget);
    for (int i = 0; i < budget && sched_state != s; i++) step();
    check(name, sched_state, s);
  endtask

  task automatic wait_samples(string name, int n, int budget);
    for (int i = 0; i < budget && sample_cnt != CW'(n); i++) step();
    check(name, sample_cnt, n);
  endtask

  // Scoreboard monitor: every handshake pops the oldest expected word.
  logic [DW-1:0] prev_out;
  logic [DW-1:0] exp_w;
  bit            prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge acc_clk);
      if (acc_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && bus.sample_valid) begin
          checks++;
          if (bus.sample_out !== prev_out) begin
            errors++;
            $display("FAIL hold_stable got=%0h exp=%0h", bus.sample_out, prev_out);
          end
        end
        if (bus.sample_valid && bus.sample_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sample_unexpected got=%0h exp=none", bus.sample_out);
          end else begin
            exp_w = exp_q.pop_front();
            if (bus.sample_out !== exp_w) begin
              errors++;
              $display("FAIL sample_order got=%0h exp=%0h", bus.sample_out, exp_w);
            end
          end
        end
        prev_stall = bus.sample_valid && !bus.sample_ready;
        prev_out   = bus.sample_out;
      end
    end
  end

  initial begin
    int bad;
    int gaps;
    int cnt0;
    bus.emptyn_to_acc = 1'b0;
    bus.data_to_acc   = '0;
    bus.sample_ready  = 1'b0;
    #2 acc_rst = 1'b1;
    run(2);
    check("rst_state", sched_state, 0);
    check("rst_ask", bus.acc_ask_data, 0);
    check("rst_valid", bus.sample_valid, 0);
    check("rst_out", bus.sample_out, 0);
    check("rst_underrun", underrun_cnt, 0);
    check("rst_samples", sample_cnt, 0);
    acc_rst = 1'b0;
    run(2);
    check("idle_after_rst", sched_state, 0);

    // paced reads every 4 cycles
    rate_div = 8'd4;
    bus.sample_ready = 1'b1;
    for (int i = 0; i < 10; i++) fifo_put(64'h1000_0000_0000_0000 + 64'(i));
    step();
    ask_cyc.delete();
    enable = 1'b1;
    wait_samples("t1_sample_cnt", 10, 120);
    check("t1_underrun", underrun_cnt, 0);
    enable = 1'b0;
    wait_state("t1_idle", 3'd0, 20);
    check("t1_ask_count", ask_cyc.size(), 10);
    bad = 0;
    for (int i = 1; i < ask_cyc.size(); i++) if (ask_cyc[i] - ask_cyc[i-1] != 4) bad++;
    check("t1_ask_interval_bad", bad, 0);
    check("t1_all_delivered", exp_q.size(), 0);

    // rate 1: one sample per cycle
    rate_div = 8'd1;
    pulse_clear();
    check("t2_clear_samples", sample_cnt, 0);
    check("t2_clear_underrun", underrun_cnt, 0);
    for (int i = 0; i < 36; i++) fifo_put(64'h2000_0000_0000_0000 + 64'(i * 3));
    step();
    enable = 1'b1;
    for (int i = 0; i < 20 && !bus.sample_valid; i++) step();
    check("t2_first_valid", bus.sample_valid, 1);
    gaps = 0;
    for (int i = 0; i < 32; i++) begin
      if (!bus.sample_valid) gaps++;
      step();
    end
    check("t2_gaps", gaps, 0);
    wait_samples("t2_sample_cnt", 36, 40);
    enable = 1'b0;
    wait_state("t2_idle", 3'd0, 20);

    // backpressure holds the tick and the head word
    rate_div = 8'd2;
    bus.sample_ready = 1'b0;
    fifo_discard();
    pulse_clear();
    for (int i = 0; i < 6; i++) fifo_put(64'h3000_0000_0000_0000 + 64'(i * 5));
    step();
    ask_cyc.delete();
    enable = 1'b1;
    run(20);
    check("t3_reads", ask_cyc.size(), 2);
    check("t3_valid", bus.sample_valid, 1);
    check("t3_head", bus.sample_out, 64'h3000_0000_0000_0000);
    check("t3_underrun_hold", underrun_cnt, 0);
    bus.sample_ready = 1'b1;
    wait_samples("t3_drained", 2, 20);
    check("t3_underrun", underrun_cnt, 0);
    enable = 1'b0;
    wait_state("t3_idle", 3'd0, 20);
    fifo_discard();

    // underrun accounting and saturation
    rate_div = 8'd3;
    pulse_clear();
    fifo_put(64'h4000_0000_0000_0000);
    step();
    enable = 1'b1;
    wait_state("t4_run", 3'd2, 10);
    hide = 1'b1;
    run(9);
    check("t4_underrun3", underrun_cnt, 3);
    rate_div = 8'd1;
    run(300);
    check("t4_underrun_sat", underrun_cnt, 8'hFF);
    run(3);
    check("t4_underrun_sat_hold", underrun_cnt, 8'hFF);
    pulse_clear();
    check("t4_clear_priority", underrun_cnt, 0);
    enable = 1'b0;
    wait_state("t4_idle", 3'd0, 20);
    fifo_discard();
    hide = 1'b0;
    step();

    // enable falls with one buffered, one landing and one granted read
    pulse_clear();
    for (int i = 0; i < 20; i++) fifo_put(64'h5000_0000_0000_0000 + 64'(i * 7));
    step();
    enable = 1'b1;
    wait_samples("t5_streaming", 3, 40);
    cnt0 = int'(sample_cnt);
    ask_cyc.delete();
    enable = 1'b0;
    step();
    check("t5_drain", sched_state, 3'd3);
    wait_state("t5_idle", 3'd0, 20);
    check("t5_delivered", sample_cnt, cnt0 + 3);
    check("t5_asks_after_fall", ask_cyc.size(), 1);
    fifo_discard();

    // flush with a full buffer and 5 words queued
    bus.sample_ready = 1'b0;
    pulse_clear();
    for (int i = 0; i < 7; i++) fifo_put(64'h6000_0000_0000_0000 + 64'(i));
    step();
    enable = 1'b1;
    run(12);
    check("t6_full_valid", bus.sample_valid, 1);
    check("t6_fifo_left", fifo_q.size(), 5);
    exp_q.delete();
    ask_cyc.delete();
    flush = 1'b1;
    enable = 1'b0;
    step();
    flush = 1'b0;
    bus.sample_ready = 1'b1;
    check("t6_valid_drop", bus.sample_valid, 0);
    check("t6_flush_state", sched_state, 3'd4);
    wait_state("t6_idle", 3'd0, 30);
    check("t6_discard_reads", ask_cyc.size(), 5);
    check("t6_sample_cnt", sample_cnt, 0);

    // reset while running
    for (int i = 0; i < 10; i++) fifo_put(64'h7000_0000_0000_0000 + 64'(i));
    step();
    enable = 1'b1;
    wait_samples("t7_running", 2, 30);
    acc_rst = 1'b1;
    enable  = 1'b0;
    #1;
    check("t7_rst_state", sched_state, 0);
    check("t7_rst_ask", bus.acc_ask_data, 0);
    check("t7_rst_valid", bus.sample_valid, 0);
    check("t7_rst_out", bus.sample_out, 0);
    check("t7_rst_samples", sample_cnt, 0);
    check("t7_rst_underrun", underrun_cnt, 0);
    fifo_discard();
    step();
    acc_rst = 1'b0;
    run(3);
    check("t7_post_state", sched_state, 0);
    check("t7_post_valid", bus.sample_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_rd_sched.md
Name: adc_rd_sched

Overview:
- Read-side scheduler for the dual-clock ADC sample FIFO, living in the acc_clk domain of rx_intf.
- Decides when to pop the FIFO (acc_ask_data) at a programmable sample interval, hides the FIFO's 1-cycle read latency behind a 2-entry output buffer, and presents samples to the rx datapath with valid/ready.
- Provides enable/drain/flush sequencing, underrun accounting and sample counting for register readback.

Parameters:
- ADC_PACK_DATA_WIDTH, 64, width of one packed ADC sample word.
- RATE_DIV_WIDTH, 8, width of the read-interval control.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- acc_clk  in  1  sole clock; FIFO read side and all logic.
- acc_rst  in  1  reset, asynchronous assert, active-high.
- enable  in  1  level; run the scheduler.
- flush  in  1  single-cycle pulse; discard FIFO and buffer contents.
- rate_div  in  RATE_DIV_WIDTH  cycles per scheduled read; 0 is treated as 1.
- clear_cnt  in  1  single-cycle pulse; zero both counters.
- emptyn_to_acc  in  1  FIFO not-empty.
- data_to_acc  in  ADC_PACK_DATA_WIDTH  FIFO read data, valid 1 cycle after acc_ask_data.
- acc_ask_data  out  1  FIFO read enable.
- sample_out  out  ADC_PACK_DATA_WIDTH  head of the output buffer.
- sample_valid  out  1  sample_out is valid.
- sample_ready  in  1  downstream accepts sample_out.
- underrun_cnt  out  CNT_WIDTH  scheduled reads missed because the FIFO was empty; saturating.
- sample_cnt  out  CNT_WIDTH  samples handed downstream; saturating.
- sched_state  out  3  current FSM state, for debug readback.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pacing counter loaded with the effective rate_div − 1, no read pending.
- acc_ask_data:
  - Asserted at most once per cycle, only when emptyn_to_acc = 1.
  - For the cycle after it is asserted, rd_pending = 1.
  - The data_to_acc value in that next cycle is pushed into the output buffer.
- Output buffer:
  - 2 entries, FIFO order.
  - sample_valid = (occupancy > 0). A pop occurs when sample_valid and sample_ready.
  - Pushes and pops in the same cycle are legal.
- Read permission (RUN state): tick_pending and emptyn_to_acc and (occupancy + rd_pending − pop) < 2.
- Pacing counter:
  - Runs only in RUN.
  - Counts down and, on reaching 0, reloads with rate_div − 1 and sets tick_pending.
  - A granted read clears tick_pending.
  - At most one tick is pending; a further expiry while pending is dropped.
  - With rate_div = 1 and sample_ready held high: one read and one output sample per cycle, steady state.
- Underrun: if the pacing counter expires while emptyn_to_acc = 0, underrun_cnt increments and that tick is discarded (tick_pending stays 0). Backpressure is not an underrun; it only holds the tick.
- Counters:
  - sample_cnt increments on every pop.
  - Both counters saturate at all-ones.
  - clear_cnt has priority over a same-cycle increment.
- FSM (sched_state encoding):
  - IDLE (0): no reads. Pacing counter held at reload value. enable = 1 → WAIT.
  - WAIT (1): no reads. emptyn_to_acc = 1 → RUN. enable = 0 → IDLE.
  - RUN (2): paced reads as above. enable = 0 → DRAIN. A read granted in the same cycle as enable falls still completes.
  - DRAIN (3): no new reads. The pending read lands and the buffer empties via normal pops. When occupancy = 0 and rd_pending = 0 → IDLE, or → WAIT if enable has returned to 1.
  - FLUSH (4):
    - Entered from any state on flush; flush has priority over all other transitions.
    - On entry the buffer is cleared and sample_valid drops the next cycle.
    - acc_ask_data = emptyn_to_acc every cycle; returned data is discarded and not counted.
    - Exit → IDLE once emptyn_to_acc = 0 and rd_pending = 0 for 2 consecutive cycles.
    - A flush received while already in FLUSH restarts the exit condition.
- sample_out must hold stable while sample_valid = 1 and sample_ready = 0.
- Asserting acc_rst mid-operation immediately returns every output to its reset value. An in-flight FIFO read is abandoned; its data is ignored.

Decomposition:
- Shared package adc_rd_sched_pkg holds:
  - the 3-bit state encoding constants (S_IDLE … S_FLUSH);
  - the output buffer depth constant (2).
- One natural sub-module, rx_sample_skid: the 2-entry valid/ready buffer with push, pop, clear and an occupancy output.

Test Plan:
- rate_div = 4, FIFO preloaded with 10 words, sample_ready = 1 → acc_ask_data pulses every 4 cycles, 10 samples out in order, sample_cnt = 10, underrun_cnt = 0.
- rate_div = 1, FIFO continuously non-empty, sample_ready = 1 for 32 cycles → 32 contiguous samples (one per cycle after 2-cycle fill latency), no gaps.
- rate_div = 2, sample_ready = 0 for 20 cycles → exactly 2 reads issued, sample_out stable, then ready = 1 drains both in order, underrun_cnt = 0.
- rate_div = 3, FIFO empty for 9 cycles in RUN → underrun_cnt = 3; at CNT_WIDTH all-ones it stays saturated; clear_cnt → 0.
- enable dropped with 2 samples buffered and one read in flight, sample_ready = 1 → all 3 delivered, state RUN→DRAIN→IDLE, no further acc_ask_data.
- flush pulse with 5 words in FIFO and buffer full → sample_valid low next cycle, 5 discarding reads, state → IDLE, sample_cnt unchanged; acc_rst mid-RUN → all outputs 0 in the same cycle.
